pc_redirect_ctrl: RTL and testbench

Owns the architectural PC register and sequences the branch/jump resolution path (jump adder target, taken decision, is-branch/jump flag) into fetch redirects.
Stalls decode while a JR/JALR/branch source register is not yet forwardable.
Holds a resolved target across instruction-fetch stalls and flushes wrong-path IF/ID contents.
Sits between the IF stage (PC, IF/ID register) and the ID-stage jump logic; also keeps taken/total branch statistics.

---
 rtl/pc_redirect_ctrl_pkg.sv | 16 +
 rtl/pc_redirect_ctrl_sat_counter.sv | 26 ++
 rtl/pc_redirect_ctrl.sv | 132 +++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: state encoding,
// NOP instruction word and default reset PC.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HAZ        = 2'd1,
    ST_REDIR_PEND = 2'd2,
    ST_HALT       = 2'd3
  } pc_state_e;

  localparam logic [15:0] NOP_INSTR        = 16'h0000;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] PC_STEP          = 16'h0002;

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // count register, frozen once it reaches all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Architectural PC owner: sequences branch/jump resolution into fetch
// redirects, stalls on rs hazards, parks targets across fetch stalls.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_ready,
  input  logic             is_bj,
  input  logic             pc_sel,
  input  logic [15:0]      pc_jump_out,
  input  logic             rs_hazard,
  input  logic             halt_id,
  output logic [15:0]      pc,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_bubble,
  output logic             redirect,
  output logic             halted,
  output logic [CNT_W-1:0] br_total_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  pc_state_e   state_r, state_nxt_s;
  logic [15:0] pc_r, pc_nxt_s;
  logic [15:0] tgt_r, tgt_nxt_s;
  logic        if_id_en_s, if_id_flush_s, id_bubble_s, redirect_s, halted_s;
  logic        inc_total_s, inc_taken_s;

  // state, pc and latched redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_PC;
      tgt_r   <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      tgt_r   <= tgt_nxt_s;
    end
  end

  // next-state and control decode; stall beats resolve beats halt beats sequential
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    tgt_nxt_s     = tgt_r;
    if_id_en_s    = 1'b0;
    if_id_flush_s = 1'b0;
    id_bubble_s   = 1'b0;
    redirect_s    = 1'b0;
    halted_s      = 1'b0;
    inc_total_s   = 1'b0;
    inc_taken_s   = 1'b0;
    case (state_r)
      ST_RUN, ST_HAZ: begin
        if (is_bj && rs_hazard) begin
          id_bubble_s = 1'b1;
          state_nxt_s = ST_HAZ;
        end else if (is_bj && pc_sel) begin
          inc_total_s   = 1'b1;
          inc_taken_s   = 1'b1;
          if_id_flush_s = 1'b1;
          if (fetch_ready) begin
            pc_nxt_s    = pc_jump_out;
            redirect_s  = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            tgt_nxt_s   = pc_jump_out;
            state_nxt_s = ST_REDIR_PEND;
          end
        end else if (!is_bj && halt_id) begin
          if_id_flush_s = 1'b1;
          state_nxt_s   = ST_HALT;
        end else begin
          // not-taken branch still counts as resolved
          inc_total_s = is_bj;
          state_nxt_s = ST_RUN;
          if (fetch_ready) begin
            pc_nxt_s   = pc_r + PC_STEP;
            if_id_en_s = 1'b1;
          end else begin
            if_id_flush_s = 1'b1;
          end
        end
      end
      ST_REDIR_PEND: begin
        if_id_flush_s = 1'b1;
        if (fetch_ready) begin
          pc_nxt_s    = tgt_r;
          redirect_s  = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_REDIR_PEND;
        end
      end
      ST_HALT: begin
        if_id_flush_s = 1'b1;
        halted_s      = 1'b1;
      end
      default: begin
        if_id_flush_s = 1'b1;
        state_nxt_s   = ST_RUN;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_total_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_total_s),
    .count (br_total_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_taken_s),
    .count (br_taken_cnt)
  );

  assign pc          = pc_r;
  assign if_id_en    = if_id_en_s;
  assign if_id_flush = if_id_flush_s;
  assign id_bubble   = id_bubble_s;
  assign redirect    = redirect_s;
  assign halted      = halted_s;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl; a second 4-bit-counter instance
// exercises counter saturation on the same stimulus.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready, is_bj, pc_sel, rs_hazard, halt_id;
  logic [15:0] pc_jump_out;
  logic [15:0] pc, pc4;
  logic        if_id_en, if_id_flush, id_bubble, redirect, halted;
  logic        en4, fl4, bub4, red4, hlt4;
  logic [15:0] tot, tak;
  logic [3:0]  tot4, tak4;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        en, flush, bubble, redir, halt;
    logic [15:0] tot, tak;
    logic [3:0]  tot4, tak4;
  } exp_t;

  exp_t exp_q[$];

  logic [1:0]  m_st;
  logic [15:0] m_pc, m_tgt, m_tot, m_tak;
  logic [3:0]  m_tot4, m_tak4;
  logic        c_en, c_fl, c_bub, c_red, c_hlt;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(16'h0000), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .is_bj(is_bj),
    .pc_sel(pc_sel), .pc_jump_out(pc_jump_out), .rs_hazard(rs_hazard),
    .halt_id(halt_id), .pc(pc), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_bubble(id_bubble), .redirect(redirect), .halted(halted),
    .br_total_cnt(tot), .br_taken_cnt(tak)
  );

  pc_redirect_ctrl #(.RESET_PC(16'h0000), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .is_bj(is_bj),
    .pc_sel(pc_sel), .pc_jump_out(pc_jump_out), .rs_hazard(rs_hazard),
    .halt_id(halt_id), .pc(pc4), .if_id_en(en4), .if_id_flush(fl4),
    .id_bubble(bub4), .redirect(red4), .halted(hlt4),
    .br_total_cnt(tot4), .br_taken_cnt(tak4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 2'd0; m_pc = 16'h0000; m_tgt = 16'h0000;
    m_tot = 16'h0000; m_tak = 16'h0000; m_tot4 = 4'h0; m_tak4 = 4'h0;
  endtask

  // Reference behaviour for one cycle, from current model state and inputs.
  function automatic exp_t predict(input logic fr, input logic bj, input logic sel,
                                   input logic [15:0] tgt, input logic haz, input logic hlt);
    exp_t e;
    e.st = m_st; e.pc = m_pc; e.tgt = m_tgt;
    e.en = 1'b0; e.flush = 1'b0; e.bubble = 1'b0; e.redir = 1'b0; e.halt = 1'b0;
    e.tot = m_tot; e.tak = m_tak; e.tot4 = m_tot4; e.tak4 = m_tak4;
    if (m_st == 2'd3) begin
      e.flush = 1'b1; e.halt = 1'b1;
    end else if (m_st == 2'd2) begin
      e.flush = 1'b1;
      if (fr) begin e.pc = m_tgt; e.redir = 1'b1; e.st = 2'd0; end
    end else if (bj && haz) begin
      e.bubble = 1'b1; e.st = 2'd1;
    end else begin
      if (bj) begin
        if (m_tot != 16'hFFFF) e.tot = m_tot + 16'h0001;
        if (m_tot4 != 4'hF) e.tot4 = m_tot4 + 4'h1;
        if (sel && m_tak != 16'hFFFF) e.tak = m_tak + 16'h0001;
        if (sel && m_tak4 != 4'hF) e.tak4 = m_tak4 + 4'h1;
      end
      if (bj && sel) begin
        e.flush = 1'b1;
        if (fr) begin e.pc = tgt; e.redir = 1'b1; e.st = 2'd0; end
        else begin e.tgt = tgt; e.st = 2'd2; end
      end else if (!bj && hlt) begin
        e.flush = 1'b1; e.st = 2'd3;
      end else begin
        e.st = 2'd0;
        if (fr) begin e.pc = m_pc + 16'h0002; e.en = 1'b1; end
        else e.flush = 1'b1;
      end
    end
    return e;
  endfunction

  // Called at a falling edge: drive, predict, capture comb outputs, compare after rise.
  task automatic step(input logic fr, input logic bj, input logic sel,
                      input logic [15:0] tgt, input logic haz, input logic hlt);
    exp_t e;
    fetch_ready = fr; is_bj = bj; pc_sel = sel; pc_jump_out = tgt;
    rs_hazard = haz; halt_id = hlt;
    exp_q.push_back(predict(fr, bj, sel, tgt, haz, hlt));
    #1;
    c_en = if_id_en; c_fl = if_id_flush; c_bub = id_bubble; c_red = redirect; c_hlt = halted;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("if_id_en", {31'd0, c_en}, {31'd0, e.en});
    check_val("if_id_flush", {31'd0, c_fl}, {31'd0, e.flush});
    check_val("id_bubble", {31'd0, c_bub}, {31'd0, e.bubble});
    check_val("redirect", {31'd0, c_red}, {31'd0, e.redir});
    check_val("halted", {31'd0, c_hlt}, {31'd0, e.halt});
    check_val("pc", {16'd0, pc}, {16'd0, e.pc});
    check_val("br_total", {16'd0, tot}, {16'd0, e.tot});
    check_val("br_taken", {16'd0, tak}, {16'd0, e.tak});
    check_val("br_total4", {28'd0, tot4}, {28'd0, e.tot4});
    check_val("br_taken4", {28'd0, tak4}, {28'd0, e.tak4});
    m_st = e.st; m_pc = e.pc; m_tgt = e.tgt;
    m_tot = e.tot; m_tak = e.tak; m_tot4 = e.tot4; m_tak4 = e.tak4;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_pc"}, {16'd0, pc}, 32'h0000_0000);
    check_val({tag, "_flush"}, {31'd0, if_id_flush}, 32'd1);
    check_val({tag, "_en"}, {31'd0, if_id_en}, 32'd0);
    check_val({tag, "_bubble"}, {31'd0, id_bubble}, 32'd0);
    check_val({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
    check_val({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check_val({tag, "_total"}, {16'd0, tot}, 32'd0);
    check_val({tag, "_taken"}, {16'd0, tak}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b0; is_bj = 1'b0; pc_sel = 1'b0;
    pc_jump_out = 16'h0000; rs_hazard = 1'b0; halt_id = 1'b0;
    model_reset();
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // sequential fetch 0 -> 2 -> 4 -> 6
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    // taken jump with fetch ready
    step(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
    // rs hazard for two cycles, then resolve (halt_id ignored under stall)
    step(1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
    // taken branch while fetch stalled; bj inputs in REDIR_PEND are ignored
    step(1'b0, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0AAA, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0BBB, 1'b0, 1'b0);
    // not-taken branch, with and without fetch
    step(1'b1, 1'b1, 1'b0, 16'h0999, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0999, 1'b0, 1'b0);
    // wrap at top of address space
    step(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    // drive the 4-bit total counter into saturation, then let taken catch up
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 16'h1000 + 16'(i * 4), 1'b0, 1'b0);
    // reset during REDIR_PEND discards the latched target
    step(1'b0, 1'b1, 1'b1, 16'h0300, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
    // halt, then frozen for 10 cycles
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 16'h0500, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
